// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. CPU stores queue bytes in a small FIFO.
// CPU loads return transmitter status one cycle later, matching the clocked memory read path.
module uart_tx_mmio #(
    parameter int          CLK_HZ     = 12000000,
    parameter int          BAUD       = 115200,
    parameter int          DIVISOR    = CLK_HZ / BAUD,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0010,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode: address[2] selects TXDATA (0) or STATUS (1); width and byte lanes are ignored.
    logic hit;
    logic push_req;
    logic ovf_clr;
    logic unused_inputs;

    assign hit           = (address[31:3] == BASE_ADDR[31:3]);
    assign push_req      = write_mem & hit & ~address[2];
    assign ovf_clr       = write_mem & hit & address[2] & write_data[3];
    assign unused_inputs = ^{funct3, address[1:0], write_data[31:8]};

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    // A pop in the same cycle frees a slot, so a store into a full FIFO still lands.
    assign push  = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    state_t           state;
    state_t           state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        tx         = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                tx = shift[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so queued bytes leave without an idle gap.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE) | ~empty;

    logic [31:0] status_word;
    assign status_word = {23'd0, 5'(count), ovf, empty, full, busy};

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
        end else begin
            read_data <= (hit && address[2]) ? status_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a line-level reference model predicts tx, busy and load data every cycle.
module tb_uart_tx_mmio;
    localparam int          DIV   = 104;
    localparam int          FRAME = 10 * DIV;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hFFFF_0010;

    logic        clk;
    logic        reset;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_tx_mmio dut (
        .clk        (clk),
        .reset      (reset),
        .write_mem  (write_mem),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending bytes in a queue, the current frame described by its start edge.
    logic [7:0]  m_q[$];
    logic [7:0]  m_byte;
    int          cyc = 0;
    int          m_start = 0;
    int          m_end = 0;
    logic        m_ovf = 1'b0;
    logic        m_tx = 1'b1;
    logic        m_busy = 1'b0;
    logic [31:0] m_rd = 32'd0;
    int          e;
    int          k;
    logic        m_hit;
    logic        m_busy_pre;
    logic [31:0] m_st;

    always @(posedge clk) begin
        e          = cyc + 1;
        cyc        = e;
        m_hit      = (address[31:3] == BASE[31:3]);
        m_busy_pre = ((e - 1) < m_end) || (m_q.size() != 0);
        m_st       = (32'(m_q.size()) << 4) + (m_ovf ? 32'd8 : 32'd0)
                   + ((m_q.size() == 0) ? 32'd4 : 32'd0)
                   + ((m_q.size() == DEPTH) ? 32'd2 : 32'd0) + (m_busy_pre ? 32'd1 : 32'd0);
        if (reset) begin
            m_q.delete();
            m_end   = e;
            m_start = e;
            m_ovf   = 1'b0;
            m_rd    = 32'd0;
        end else begin
            m_rd = (m_hit && address[2]) ? m_st : 32'd0;
            if (m_q.size() != 0 && e >= m_end) begin
                m_byte  = m_q.pop_front();
                m_start = e;
                m_end   = e + FRAME;
            end
            if (write_mem && m_hit && !address[2]) begin
                if (m_q.size() < DEPTH) m_q.push_back(write_data[7:0]);
                else m_ovf = 1'b1;
            end
            if (write_mem && m_hit && address[2] && write_data[3]) m_ovf = 1'b0;
        end
        if (e < m_end) begin
            k = (e - m_start) / DIV;
            if (k == 0) m_tx = 1'b0;
            else if (k <= 8) m_tx = m_byte[k-1];
            else m_tx = 1'b1;
        end else begin
            m_tx = 1'b1;
        end
        m_busy = (e < m_end) || (m_q.size() != 0);
    end

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        write_mem  = we;
        address    = a;
        write_data = d;
        funct3     = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        write_mem = 1'b0;
    endtask

    task automatic drive_idle();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0:       a = BASE;
            1:       a = BASE + 32'd4;
            2:       a = BASE + 32'd6;
            default: a = BASE + 32'd8;
        endcase
        drive(1'b0, a, $urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        drive(1'b0, 32'd0, 32'd0);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || read_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: tx=%b busy=%b rd=%h expected tx=1 busy=0 rd=0", tx, busy, read_data);
        end
        reset = 1'b0;
        drive(1'b0, BASE + 32'd4, 32'd0);
        total++;
        if (read_data !== 32'h4 || read_data !== m_rd) begin
            bad++;
            $display("FAIL reset_status: rd=%h expected 4 (model %h)", read_data, m_rd);
        end
    endtask

    task automatic test_single();
        int fall_at = -1;
        drive(1'b1, BASE, 32'h55);
        for (int i = 1; i <= FRAME + 8; i++) begin
            drive_idle();
            total++;
            if (tx !== m_tx || busy !== m_busy || read_data !== m_rd) begin
                bad++;
                $display("FAIL single: cyc=%0d tx=%b/%b busy=%b/%b rd=%h/%h", i, tx, m_tx, busy, m_busy, read_data, m_rd);
            end
            if (fall_at < 0 && busy === 1'b0) fall_at = i;
        end
        total++;
        if (fall_at != FRAME + 1) begin
            bad++;
            $display("FAIL single_busy_len: busy low at %0d expected %0d", fall_at, FRAME + 1);
        end
    endtask

    task automatic test_back_to_back();
        int low_cnt = 0;
        drive(1'b1, BASE, 32'hA5);
        drive(1'b1, BASE + 32'd1, 32'h3C);
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            drive_idle();
            if (busy === 1'b1) low_cnt++;
            total++;
            if (tx !== m_tx || busy !== m_busy || read_data !== m_rd) begin
                bad++;
                $display("FAIL back_to_back: cyc=%0d tx=%b/%b busy=%b/%b rd=%h/%h", i, tx, m_tx, busy, m_busy, read_data, m_rd);
            end
        end
        // One busy cycle (after E1) was spent inside the second drive.
        total++;
        if (low_cnt != 2 * FRAME - 1) begin
            bad++;
            $display("FAIL back_to_back_len: busy cycles=%0d expected %0d", low_cnt, 2 * FRAME - 1);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) drive(1'b1, BASE, 32'($urandom_range(0, 255)));
        drive(1'b0, BASE + 32'd4, 32'd0);
        total++;
        if (read_data !== 32'h8B || read_data !== m_rd) begin
            bad++;
            $display("FAIL overflow_status: rd=%h expected 8b (model %h)", read_data, m_rd);
        end
        drive(1'b1, BASE + 32'd4, 32'h8);
        drive(1'b0, BASE + 32'd4, 32'd0);
        total++;
        if (read_data !== 32'h83 || read_data !== m_rd) begin
            bad++;
            $display("FAIL overflow_clear: rd=%h expected 83 (model %h)", read_data, m_rd);
        end
        for (int i = 0; i < 9 * FRAME + 10; i++) begin
            drive_idle();
            total++;
            if (tx !== m_tx || busy !== m_busy || read_data !== m_rd) begin
                bad++;
                $display("FAIL overflow_frames: cyc=%0d tx=%b/%b busy=%b/%b rd=%h/%h", i, tx, m_tx, busy, m_busy, read_data, m_rd);
            end
        end
    endtask

    task automatic test_random();
        int budget = 0;
        for (int n = 0; n < 16; n++) begin
            for (int g = $urandom_range(0, 300); g > 0; g--) begin
                drive_idle();
                total++;
                if (tx !== m_tx || busy !== m_busy || read_data !== m_rd) begin
                    bad++;
                    $display("FAIL random_gap: n=%0d tx=%b/%b busy=%b/%b rd=%h/%h", n, tx, m_tx, busy, m_busy, read_data, m_rd);
                end
            end
            if ($urandom_range(0, 5) == 0) drive(1'b1, BASE + 32'd4, $urandom);
            else drive(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
            total++;
            if (tx !== m_tx || busy !== m_busy || read_data !== m_rd) begin
                bad++;
                $display("FAIL random_store: n=%0d tx=%b/%b busy=%b/%b rd=%h/%h", n, tx, m_tx, busy, m_busy, read_data, m_rd);
            end
        end
        while ((m_busy || busy === 1'b1) && budget < 12000) begin
            drive_idle();
            budget++;
            total++;
            if (tx !== m_tx || busy !== m_busy || read_data !== m_rd) begin
                bad++;
                $display("FAIL random_drain: t=%0d tx=%b/%b busy=%b/%b rd=%h/%h", budget, tx, m_tx, busy, m_busy, read_data, m_rd);
            end
        end
        total++;
        if (budget >= 12000) begin
            bad++;
            $display("FAIL random_timeout: busy=%b after %0d cycles, expected 0", busy, budget);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, BASE, 32'hFF);
        for (int i = 0; i < 4 * DIV + 50; i++) drive_idle();
        total++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: tx=%b busy=%b expected tx=1 busy=1", tx, busy);
        end
        reset = 1'b1;
        drive_idle();
        reset = 1'b0;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || read_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: tx=%b busy=%b rd=%h expected tx=1 busy=0 rd=0", tx, busy, read_data);
        end
        drive(1'b0, BASE + 32'd4, 32'd0);
        total++;
        if (read_data !== 32'h4) begin
            bad++;
            $display("FAIL reset_mid_status: rd=%h expected 4", read_data);
        end
        for (int i = 0; i < FRAME + 20; i++) begin
            drive_idle();
            total++;
            if (tx !== 1'b1 || busy !== 1'b0 || read_data !== m_rd) begin
                bad++;
                $display("FAIL reset_mid_quiet: cyc=%0d tx=%b busy=%b rd=%h/%h", i, tx, busy, read_data, m_rd);
            end
        end
    endtask

    task automatic test_off_window();
        drive(1'b1, BASE + 32'd8, 32'h41);
        drive(1'b1, BASE - 32'd4, 32'h42);
        drive(1'b0, BASE + 32'd8, 32'd0);
        drive(1'b0, BASE - 32'd4, 32'd0);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (tx !== 1'b1 || busy !== 1'b0 || read_data !== 32'd0) begin
                bad++;
                $display("FAIL off_window: cyc=%0d tx=%b busy=%b rd=%h expected tx=1 busy=0 rd=0", i, tx, busy, read_data);
            end
            drive(1'b0, (i % 2 == 0) ? BASE + 32'd12 : BASE - 32'd8, $urandom);
        end
        drive(1'b0, BASE + 32'd4, 32'd0);
        total++;
        if (read_data !== 32'h4) begin
            bad++;
            $display("FAIL off_window_status: rd=%h expected 4", read_data);
        end
    endtask

    initial begin
        reset      = 1'b1;
        write_mem  = 1'b0;
        funct3     = 3'd0;
        address    = 32'd0;
        write_data = 32'd0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid();
        test_off_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
